freq_calc_period: RTL

Downstream stage of the square-wave period detector. It takes the averaged period count (clock cycles per input period) and its stable flag, and converts them to a frequency in Hz with a sequential restoring divider: freq = round(CLK_FREQ / period). The result is held for the display/UART layers, with a level valid flag and a one-cycle done pulse.

---
 rtl/freq_calc_period.sv | 113 +++++++++++
 1 files changed

// File: rtl/freq_calc_period.sv
// Converts a stable averaged period (clk cycles) into a frequency in Hz using a
// bit-serial restoring divider: freq = round(CLK_FREQ / period).
module freq_calc_period #(
  parameter int CLK_FREQ      = 200_000_000,
  parameter int COUNTER_WIDTH = 18,
  parameter int FREQ_WIDTH    = 28
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [COUNTER_WIDTH-1:0] period,
  input  logic                     stable,
  output logic [FREQ_WIDTH-1:0]    freq,
  output logic                     freq_valid,
  output logic                     freq_done,
  output logic                     busy
);

  localparam int CNT_W = $clog2(FREQ_WIDTH);
  localparam logic [FREQ_WIDTH-1:0] CLK_FREQ_W = FREQ_WIDTH'(CLK_FREQ);
  localparam logic [CNT_W-1:0]      LAST_BIT   = CNT_W'(FREQ_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t                   state_reg;
  logic [FREQ_WIDTH-1:0]    dividend_reg;
  logic [FREQ_WIDTH-1:0]    quotient_reg;
  logic [COUNTER_WIDTH-1:0] divisor_reg;
  logic [COUNTER_WIDTH-1:0] remainder_reg;
  logic [COUNTER_WIDTH-1:0] last_period_reg;
  logic [CNT_W-1:0]         bit_cnt_reg;

  logic [COUNTER_WIDTH:0]   trial;
  logic                     trial_ge;
  logic [COUNTER_WIDTH-1:0] remainder_next;
  logic                     start;

  // One restoring step: remainder never exceeds the divisor, so it fits COUNTER_WIDTH bits.
  assign trial          = {remainder_reg, dividend_reg[FREQ_WIDTH-1]};
  assign trial_ge       = (trial >= {1'b0, divisor_reg});
  assign remainder_next = trial_ge ? COUNTER_WIDTH'(trial - {1'b0, divisor_reg})
                                   : trial[COUNTER_WIDTH-1:0];

  assign start = stable && (period != '0) && (!freq_valid || (period != last_period_reg));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      dividend_reg    <= '0;
      quotient_reg    <= '0;
      divisor_reg     <= '0;
      remainder_reg   <= '0;
      last_period_reg <= '0;
      bit_cnt_reg     <= '0;
      freq            <= '0;
      freq_valid      <= 1'b0;
      freq_done       <= 1'b0;
      busy            <= 1'b0;
    end else begin
      freq_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!stable) begin
            freq_valid <= 1'b0;
          end else if (start) begin
            // Adding half the divisor to the dividend rounds half up.
            dividend_reg  <= CLK_FREQ_W + FREQ_WIDTH'(period >> 1);
            divisor_reg   <= period;
            remainder_reg <= '0;
            quotient_reg  <= '0;
            bit_cnt_reg   <= LAST_BIT;
            busy          <= 1'b1;
            state_reg     <= DIV;
          end
        end

        DIV: begin
          if (!stable) begin
            freq_valid <= 1'b0;
            busy       <= 1'b0;
            state_reg  <= IDLE;
          end else begin
            remainder_reg <= remainder_next;
            quotient_reg  <= {quotient_reg[FREQ_WIDTH-2:0], trial_ge};
            dividend_reg  <= dividend_reg << 1;
            bit_cnt_reg   <= bit_cnt_reg - CNT_W'(1);
            if (bit_cnt_reg == '0) begin
              state_reg <= DONE;
            end
          end
        end

        DONE: begin
          if (stable) begin
            freq            <= quotient_reg;
            last_period_reg <= divisor_reg;
            freq_valid      <= 1'b1;
            freq_done       <= 1'b1;
          end else begin
            freq_valid <= 1'b0;
          end
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
